// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - byte-stream in / memory write port out bundle for mem_loader
interface mem_loader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             start;
    logic [ADDRW-1:0] base_addr;
    logic [ADDRW:0]   len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             we;
    logic [ADDRW-1:0] waddr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;

    modport master (
        output start, base_addr, len, in_data, in_valid,
        input  in_ready, we, waddr, wdata, busy, done
    );

    modport slave (
        input  start, base_addr, len, in_data, in_valid,
        output in_ready, we, waddr, wdata, busy, done
    );
endinterface

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - packs a byte stream little-endian into words and writes them to a memory block
module mem_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_loader_if.slave  bus
);
    localparam int ADDRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NBYTES = WIDTH / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [ADDRW:0]   remaining_q, remaining_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDRW-1:0] waddr_q, waddr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        bcnt_d       = bcnt_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        bus.in_ready = 1'b0;
        bus.we       = 1'b0;
        bus.done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.len;
                    bcnt_d      = '0;
                    state_d     = (bus.len == '0) ? S_DONE : S_COLLECT;
                end
            end

            S_COLLECT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (bcnt_q == BCW'(b)) begin
                            word_d[8*b +: 8] = bus.in_data;
                        end
                    end
                    // wdata/waddr are captured here so they stay stable through WRITE and after
                    if (bcnt_q == BCW'(NBYTES - 1)) begin
                        wdata_d = word_d;
                        waddr_d = addr_q;
                        state_d = S_WRITE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end

            S_WRITE: begin
                bus.we      = 1'b1;
                addr_d      = (addr_q == ADDRW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                bcnt_d      = '0;
                state_d     = (remaining_q == (ADDRW + 1)'(1)) ? S_DONE : S_COLLECT;
            end

            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - randomized directed bench for mem_loader against a word-packing model
module tb_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_loader_if #(.WIDTH(8),  .DEPTH(256)) ifc8  ();
    mem_loader_if #(.WIDTH(32), .DEPTH(256)) ifc32 ();
    mem_loader_if #(.WIDTH(8),  .DEPTH(6))   ifc6  ();

    mem_loader #(.WIDTH(8),  .DEPTH(256)) dut8  (.clk_i(clk), .rst_i(rst), .bus(ifc8));
    mem_loader #(.WIDTH(32), .DEPTH(256)) dut32 (.clk_i(clk), .rst_i(rst), .bus(ifc32));
    mem_loader #(.WIDTH(8),  .DEPTH(6))   dut6  (.clk_i(clk), .rst_i(rst), .bus(ifc6));

    int          act = 0;
    int          viol = 0;
    int          last_we = -10;
    int          we_cyc_q[$];
    logic [31:0] we_addr_q[$];
    logic [31:0] we_data_q[$];
    int          done_q[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic st, input int base, input int len,
                         input logic [7:0] b, input logic v);
        case (s)
            0: begin ifc8.start = st; ifc8.base_addr = 8'(base); ifc8.len = 9'(len);
                     ifc8.in_data = b; ifc8.in_valid = v; end
            1: begin ifc32.start = st; ifc32.base_addr = 8'(base); ifc32.len = 9'(len);
                     ifc32.in_data = b; ifc32.in_valid = v; end
            default: begin ifc6.start = st; ifc6.base_addr = 3'(base); ifc6.len = 4'(len);
                     ifc6.in_data = b; ifc6.in_valid = v; end
        endcase
    endtask

    task automatic get_out(input int s, output logic we, output logic rdy, output logic dn,
                           output logic bsy, output logic [31:0] a, output logic [31:0] d);
        case (s)
            0: begin we = ifc8.we; rdy = ifc8.in_ready; dn = ifc8.done; bsy = ifc8.busy;
                     a = 32'(ifc8.waddr); d = 32'(ifc8.wdata); end
            1: begin we = ifc32.we; rdy = ifc32.in_ready; dn = ifc32.done; bsy = ifc32.busy;
                     a = 32'(ifc32.waddr); d = ifc32.wdata; end
            default: begin we = ifc6.we; rdy = ifc6.in_ready; dn = ifc6.done; bsy = ifc6.busy;
                     a = 32'(ifc6.waddr); d = 32'(ifc6.wdata); end
        endcase
    endtask

    // Capture every write and done pulse of the active DUT; flag back-to-back we or ready during a write
    always @(negedge clk) begin
        logic w, r, dn, b;
        logic [31:0] a, d;
        get_out(act, w, r, dn, b, a, d);
        if (w) begin
            if (r || last_we == cyc - 1) viol++;
            last_we = cyc;
            we_cyc_q.push_back(cyc);
            we_addr_q.push_back(a);
            we_data_q.push_back(d);
        end
        if (dn) done_q.push_back(cyc);
    end

    task automatic clear_mon(input int s);
        act = s;
        viol = 0;
        last_we = -10;
        we_cyc_q.delete();
        we_addr_q.delete();
        we_data_q.delete();
        done_q.delete();
    endtask

    task automatic do_load(input string tag, input int s, input int base, input int len,
                           input logic [7:0] bytes[$], input int gap_pct, input bit mid_start);
        int nb    = (s == 1) ? 4 : 1;
        int depth = (s == 2) ? 6 : 256;
        int total = len * nb;
        int idx = 0, guard = 0, acc_last = -1, start_acc;
        bit ms_done = 0;
        logic v, st, w, r, dn, b;
        logic [31:0] a, d, ew;

        clear_mon(s);
        @(negedge clk);
        drive(s, 1'b1, base, len, 8'h00, 1'b0);
        start_acc = cyc + 1;
        while (idx < total && guard < 4000) begin
            @(negedge clk);
            guard++;
            v  = ($urandom_range(99) >= gap_pct);
            st = 1'b0;
            if (mid_start && !ms_done && idx == total / 2) begin
                st = 1'b1;
                ms_done = 1;
            end
            drive(s, st, (base + 7) % depth, len, bytes[idx], v);
            get_out(s, w, r, dn, b, a, d);
            if (v && r) begin
                idx++;
                acc_last = cyc + 1;
            end
        end
        guard = 0;
        while (done_q.size() == 0 && guard < 100) begin
            @(negedge clk);
            get_out(s, w, r, dn, b, a, d);
            drive(s, mid_start && dn, (base + 3) % depth, len, 8'h00, 1'b0);
            guard++;
        end
        @(negedge clk);
        drive(s, 1'b0, 0, 0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);

        check({tag, ".bytes"}, idx, total);
        check({tag, ".nwrites"}, we_addr_q.size(), len);
        for (int wi = 0; wi < len && wi < we_addr_q.size(); wi++) begin
            ew = '0;
            for (int j = 0; j < nb; j++) ew |= 32'(bytes[wi*nb + j]) << (8 * j);
            check($sformatf("%s.addr[%0d]", tag, wi), we_addr_q[wi], (base + wi) % depth);
            check($sformatf("%s.data[%0d]", tag, wi), we_data_q[wi], ew);
        end
        check({tag, ".ndone"}, done_q.size(), 1);
        if (done_q.size() > 0) begin
            if (we_cyc_q.size() > 0) begin
                check({tag, ".we_lat"}, we_cyc_q[$], acc_last);
                check({tag, ".done_lat"}, done_q[0], we_cyc_q[$] + 1);
            end else begin
                check({tag, ".done_lat"}, done_q[0], start_acc);
            end
        end
        check({tag, ".viol"}, viol, 0);
        get_out(s, w, r, dn, b, a, d);
        check({tag, ".idle_busy"}, b, 0);
    endtask

    logic [7:0] bq[$];

    initial begin
        logic w, r, dn, b;
        logic [31:0] a, d;
        int n, guard, base;

        for (int s = 0; s < 3; s++) drive(s, 1'b0, 0, 0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            get_out(s, w, r, dn, b, a, d);
            check($sformatf("reset.ctl%0d", s), {w, r, dn, b}, 0);
            check($sformatf("reset.waddr%0d", s), a, 0);
            check($sformatf("reset.wdata%0d", s), d, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        bq = {8'hAA, 8'hBB, 8'hCC};
        do_load("s1_w8", 0, 'h10, 3, bq, 0, 0);

        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load("s2_w32", 1, 5, 2, bq, 0, 0);

        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        do_load("s3_wrap256", 0, 'hFE, 4, bq, 0, 0);

        bq.delete();
        for (int i = 0; i < 2; i++) bq.push_back(8'($urandom));
        do_load("s3_wrap6", 2, 5, 2, bq, 0, 0);

        bq.delete();
        do_load("s4_len0", 0, 'h33, 0, bq, 0, 0);

        bq.delete();
        for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
        do_load("s5_gaps32", 1, $urandom_range(255), 5, bq, 40, 1);

        bq.delete();
        for (int i = 0; i < 256; i++) bq.push_back(8'($urandom));
        do_load("full256", 0, $urandom_range(255), 256, bq, 30, 1);

        bq.delete();
        for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
        do_load("full6", 2, 3, 6, bq, 50, 1);

        clear_mon(1);
        @(negedge clk);
        drive(1, 1'b1, 5, 4, 8'h00, 1'b0);
        n = 0;
        guard = 0;
        while (n < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
            drive(1, 1'b0, 5, 4, 8'(8'h11 + n), 1'b1);
            get_out(1, w, r, dn, b, a, d);
            if (r) n++;
        end
        @(negedge clk);
        drive(1, 1'b0, 0, 0, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        get_out(1, w, r, dn, b, a, d);
        check("s6_rst.ctl", {w, r, dn, b}, 0);
        check("s6_rst.waddr", a, 0);
        check("s6_rst.wdata", d, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("s6_rst.nwrites", we_addr_q.size(), 0);
        check("s6_rst.ndone", done_q.size(), 0);

        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        base = 5;
        do_load("s6_reload", 1, base, 2, bq, 20, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
